// File: rtl/pipe_writeback_rf_if.sv
// Bus bundle between the pipeline and the writeback/register-file block:
// memory-stage results in, decode read ports, W-stage forwarding and status out.
interface pipe_writeback_rf_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
);
    logic              w_stall;
    logic              w_bubble;
    logic [3:0]        m_icode;
    logic              m_cnd;
    logic [ADDR_W-1:0] m_ra;
    logic [ADDR_W-1:0] m_rb;
    logic [DATA_W-1:0] m_vale;
    logic [DATA_W-1:0] m_valm;
    logic [2:0]        m_stat;
    logic [ADDR_W-1:0] srca;
    logic [ADDR_W-1:0] srcb;
    logic [DATA_W-1:0] vala;
    logic [DATA_W-1:0] valb;
    logic [ADDR_W-1:0] w_dste;
    logic [ADDR_W-1:0] w_dstm;
    logic [DATA_W-1:0] w_vale;
    logic [DATA_W-1:0] w_valm;
    logic [2:0]        w_stat;
    logic              halted;
    logic [CNT_W-1:0]  retired;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output w_stall, w_bubble, m_icode, m_cnd, m_ra, m_rb, m_vale, m_valm, m_stat,
               srca, srcb, dbg_addr,
        input  vala, valb, w_dste, w_dstm, w_vale, w_valm, w_stat, halted, retired, dbg_data
    );

    modport slave (
        input  w_stall, w_bubble, m_icode, m_cnd, m_ra, m_rb, m_vale, m_valm, m_stat,
               srca, srcb, dbg_addr,
        output vala, valb, w_dste, w_dstm, w_vale, w_valm, w_stat, halted, retired, dbg_data
    );
endinterface

// File: rtl/pipe_writeback_rf.sv
// Y86-64 writeback stage: W pipeline register, dual-write register file with
// bypassed decode reads, sticky halt and retired-instruction counter.
module pipe_writeback_rf #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 4,
    parameter int NREG    = 15,
    parameter int RSP_IDX = 4,
    parameter int CNT_W   = 32
) (
    input logic clock,
    input logic reset,
    pipe_writeback_rf_if.slave bus
);
    localparam logic [ADDR_W-1:0] RNONE    = '1;
    localparam logic [ADDR_W-1:0] RSP      = ADDR_W'(RSP_IDX);
    localparam logic [2:0]        STAT_AOK = 3'd1;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [3:0]        w_icode;
    logic              w_cnd;
    logic [ADDR_W-1:0] w_ra;
    logic [ADDR_W-1:0] w_rb;
    logic [DATA_W-1:0] w_vale_q;
    logic [DATA_W-1:0] w_valm_q;
    logic [2:0]        w_stat_q;
    logic              w_is_bubble;
    logic              commit_done;
    logic              halted_q;
    logic [CNT_W-1:0]  retired_q;
    logic [DATA_W-1:0] regs [NREG];

    logic [ADDR_W-1:0] dst_e;
    logic [ADDR_W-1:0] dst_m;
    logic              commit_active;

    function automatic logic in_rf(input logic [ADDR_W-1:0] a);
        return (a != RNONE) && (int'(a) < NREG);
    endfunction

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (w_icode)
            I_RRMOVQ:                begin if (w_cnd) dst_e = w_rb; end
            I_IRMOVQ, I_OPQ:         dst_e = w_rb;
            I_CALL, I_RET, I_PUSHQ:  dst_e = RSP;
            I_POPQ:                  begin dst_e = RSP; dst_m = w_ra; end
            I_MRMOVQ:                dst_m = w_ra;
            default:                 ;
        endcase
    end

    // A held instruction commits once; commit_done blocks repeats while stalled.
    assign commit_active = (w_stat_q == STAT_AOK) && !halted_q && !commit_done;

    always_ff @(posedge clock) begin
        if (reset || bus.w_bubble) begin
            w_icode     <= I_NOP;
            w_cnd       <= 1'b0;
            w_ra        <= '0;
            w_rb        <= '0;
            w_vale_q    <= '0;
            w_valm_q    <= '0;
            w_stat_q    <= STAT_AOK;
            w_is_bubble <= 1'b1;
            commit_done <= 1'b0;
        end else if (bus.w_stall) begin
            commit_done <= commit_done | commit_active;
        end else begin
            w_icode     <= bus.m_icode;
            w_cnd       <= bus.m_cnd;
            w_ra        <= bus.m_ra;
            w_rb        <= bus.m_rb;
            w_vale_q    <= bus.m_vale;
            w_valm_q    <= bus.m_valm;
            w_stat_q    <= bus.m_stat;
            w_is_bubble <= 1'b0;
            commit_done <= 1'b0;
        end
    end

    // The M write follows the E write so that popq %rsp leaves valm in %rsp.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            if (commit_active) begin
                if (in_rf(dst_e)) regs[dst_e] <= w_vale_q;
                if (in_rf(dst_m)) regs[dst_m] <= w_valm_q;
                if (!w_is_bubble) retired_q <= retired_q + CNT_W'(1);
            end
            if (w_stat_q != STAT_AOK) halted_q <= 1'b1;
        end
    end

    always_comb begin
        bus.vala = '0;
        if (in_rf(bus.srca)) begin
            if (commit_active && bus.srca == dst_m)      bus.vala = w_valm_q;
            else if (commit_active && bus.srca == dst_e) bus.vala = w_vale_q;
            else                                         bus.vala = regs[bus.srca];
        end
    end

    always_comb begin
        bus.valb = '0;
        if (in_rf(bus.srcb)) begin
            if (commit_active && bus.srcb == dst_m)      bus.valb = w_valm_q;
            else if (commit_active && bus.srcb == dst_e) bus.valb = w_vale_q;
            else                                         bus.valb = regs[bus.srcb];
        end
    end

    always_comb begin
        bus.dbg_data = '0;
        if (in_rf(bus.dbg_addr)) bus.dbg_data = regs[bus.dbg_addr];
    end

    assign bus.w_dste  = dst_e;
    assign bus.w_dstm  = dst_m;
    assign bus.w_vale  = w_vale_q;
    assign bus.w_valm  = w_valm_q;
    assign bus.w_stat  = w_stat_q;
    assign bus.halted  = halted_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_pipe_writeback_rf.sv
// Directed and randomized bench for pipe_writeback_rf, checked against an
// instruction-level model of register file, W contents, halt and retire count.
module tb_pipe_writeback_rf;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pipe_writeback_rf_if bus ();

    pipe_writeback_rf dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state: architectural registers plus the instruction sitting in W.
    logic [63:0] ref_rf [16];
    logic [3:0]  ref_icode, ref_ra, ref_rb;
    logic        ref_cnd, ref_bubble, ref_done, ref_halted;
    logic [63:0] ref_vale, ref_valm;
    logic [2:0]  ref_stat;
    logic [31:0] ref_retired;

    function automatic logic [3:0] ref_dst_e();
        if (ref_icode == 4'h3 || ref_icode == 4'h6 || (ref_icode == 4'h2 && ref_cnd)) return ref_rb;
        if (ref_icode >= 4'h8 && ref_icode <= 4'hB) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dst_m();
        return (ref_icode == 4'h5 || ref_icode == 4'hB) ? ref_ra : 4'hF;
    endfunction

    function automatic logic ref_commit();
        return (ref_stat == 3'd1) && !ref_halted && !ref_done;
    endfunction

    function automatic logic [63:0] ref_read(input logic [3:0] src);
        if (src == 4'hF) return 64'd0;
        if (ref_commit() && src == ref_dst_m()) return ref_valm;
        if (ref_commit() && src == ref_dst_e()) return ref_vale;
        return ref_rf[src];
    endfunction

    task automatic setNop();
        ref_icode = 4'h1; ref_cnd = 1'b0; ref_ra = 4'h0; ref_rb = 4'h0;
        ref_vale = 64'd0; ref_valm = 64'd0; ref_stat = 3'd1;
        ref_bubble = 1'b1; ref_done = 1'b0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) ref_rf[i] = 64'd0;
        setNop();
        ref_halted  = 1'b0;
        ref_retired = 32'd0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then compare every output to the model.
    task automatic applyStimulus(
        input logic [3:0] icode, input logic cnd, input logic [3:0] ra, input logic [3:0] rb,
        input logic [63:0] vale, input logic [63:0] valm, input logic [2:0] stat,
        input logic stall, input logic bubble,
        input logic [3:0] srca, input logic [3:0] srcb, input logic [3:0] dbg);
        @(negedge clock);
        bus.m_icode = icode; bus.m_cnd = cnd; bus.m_ra = ra; bus.m_rb = rb;
        bus.m_vale = vale; bus.m_valm = valm; bus.m_stat = stat;
        bus.w_stall = stall; bus.w_bubble = bubble;
        bus.srca = srca; bus.srcb = srcb; bus.dbg_addr = dbg;
        #1;
        checkOutput("vala", bus.vala, ref_read(srca));
        checkOutput("valb", bus.valb, ref_read(srcb));
        checkOutput("dbg_data", bus.dbg_data, ref_rf[dbg]);
        checkOutput("w_dste", 64'(bus.w_dste), 64'(ref_dst_e()));
        checkOutput("w_dstm", 64'(bus.w_dstm), 64'(ref_dst_m()));
        checkOutput("w_vale", bus.w_vale, ref_vale);
        checkOutput("w_valm", bus.w_valm, ref_valm);
        checkOutput("w_stat", 64'(bus.w_stat), 64'(ref_stat));
        checkOutput("halted", 64'(bus.halted), 64'(ref_halted));
        checkOutput("retired", 64'(bus.retired), 64'(ref_retired));
    endtask

    task automatic stepClock();
        logic       act;
        logic [3:0] de, dm;
        @(posedge clock);
        if (reset) begin
            modelReset();
        end else begin
            act = ref_commit();
            de  = ref_dst_e();
            dm  = ref_dst_m();
            if (act) begin
                if (de != 4'hF) ref_rf[de] = ref_vale;
                if (dm != 4'hF) ref_rf[dm] = ref_valm;
                if (!ref_bubble) ref_retired = ref_retired + 32'd1;
            end
            if (ref_stat != 3'd1) ref_halted = 1'b1;
            if (bus.w_bubble) setNop();
            else if (bus.w_stall) ref_done = ref_done | act;
            else begin
                ref_icode = bus.m_icode; ref_cnd = bus.m_cnd; ref_ra = bus.m_ra; ref_rb = bus.m_rb;
                ref_vale = bus.m_vale; ref_valm = bus.m_valm; ref_stat = bus.m_stat;
                ref_bubble = 1'b0; ref_done = 1'b0;
            end
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        bus.w_bubble = 1'b1;
        bus.w_stall  = 1'b0;
        stepClock();
        #1 reset = 1'b0;
    endtask

    task automatic loadInstr(input logic [3:0] icode, input logic cnd, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [63:0] vale, input logic [63:0] valm,
                             input logic [2:0] stat);
        applyStimulus(icode, cnd, ra, rb, vale, valm, stat, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0);
        stepClock();
    endtask

    task automatic idle(input logic [3:0] src, input logic [3:0] dbg);
        applyStimulus(4'h1, 1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 3'd1, 1'b0, 1'b1, src, src, dbg);
    endtask

    initial begin
        reset = 1'b1;
        bus.w_stall = 1'b0; bus.w_bubble = 1'b1;
        bus.m_icode = 4'h1; bus.m_cnd = 1'b0; bus.m_ra = 4'h0; bus.m_rb = 4'h0;
        bus.m_vale = 64'd0; bus.m_valm = 64'd0; bus.m_stat = 3'd1;
        bus.srca = 4'hF; bus.srcb = 4'hF; bus.dbg_addr = 4'h0;
        modelReset();

        doReset();
        idle(4'h1, 4'h1);
        checkOutput("rst_dste", 64'(bus.w_dste), 64'hF);
        checkOutput("rst_dstm", 64'(bus.w_dstm), 64'hF);
        checkOutput("rst_stat", 64'(bus.w_stat), 64'd1);
        checkOutput("rst_halted", 64'(bus.halted), 64'd0);
        checkOutput("rst_retired", 64'(bus.retired), 64'd0);
        checkOutput("rst_vala", bus.vala, 64'd0);
        stepClock();

        loadInstr(4'h6, 1'b0, 4'h0, 4'h8, 64'd45, 64'd33, 3'd1);
        idle(4'hF, 4'h8); stepClock();
        for (int i = 0; i < 15; i++) begin
            idle(4'hF, 4'(i));
            checkOutput("opq_reg", bus.dbg_data, (i == 8) ? 64'd45 : 64'd0);
            stepClock();
        end
        checkOutput("opq_retired", 64'(bus.retired), 64'd1);

        loadInstr(4'h2, 1'b0, 4'h0, 4'h4, 64'd100, 64'd0, 3'd1);
        idle(4'hF, 4'h4); stepClock();
        idle(4'hF, 4'h4);
        checkOutput("cmov_nc_r4", bus.dbg_data, 64'd0);
        checkOutput("cmov_nc_retired", 64'(bus.retired), 64'd2);
        stepClock();
        loadInstr(4'h2, 1'b1, 4'h0, 4'h4, 64'd100, 64'd0, 3'd1);
        idle(4'hF, 4'h4); stepClock();
        idle(4'hF, 4'h4);
        checkOutput("cmov_c_r4", bus.dbg_data, 64'd100);
        stepClock();

        loadInstr(4'h9, 1'b0, 4'hF, 4'hF, 64'd20, 64'd0, 3'd1);
        idle(4'hF, 4'h4); stepClock();
        idle(4'hF, 4'h4);
        checkOutput("ret_rsp", bus.dbg_data, 64'd20);
        stepClock();
        loadInstr(4'hB, 1'b0, 4'h4, 4'hF, 64'd28, 64'd7, 3'd1);
        idle(4'hF, 4'h4); stepClock();
        idle(4'hF, 4'h4);
        checkOutput("popq_rsp", bus.dbg_data, 64'd7);
        checkOutput("popq_retired", 64'(bus.retired), 64'd5);
        stepClock();

        loadInstr(4'h5, 1'b0, 4'h3, 4'hF, 64'd0, 64'hDEAD, 3'd1);
        idle(4'h3, 4'h3);
        checkOutput("bypass_vala", bus.vala, 64'hDEAD);
        checkOutput("bypass_dbg_old", bus.dbg_data, 64'd0);
        stepClock();
        idle(4'hF, 4'h3);
        checkOutput("bypass_dbg_new", bus.dbg_data, 64'hDEAD);
        checkOutput("bypass_retired", 64'(bus.retired), 64'd6);
        stepClock();

        loadInstr(4'h6, 1'b0, 4'h0, 4'h1, 64'd55, 64'd0, 3'd2);
        idle(4'hF, 4'h1); stepClock();
        idle(4'hF, 4'h1);
        checkOutput("halt_flag", 64'(bus.halted), 64'd1);
        checkOutput("halt_r1", bus.dbg_data, 64'd0);
        stepClock();
        loadInstr(4'h6, 1'b0, 4'h0, 4'h2, 64'd9, 64'd0, 3'd1);
        idle(4'hF, 4'h2); stepClock();
        idle(4'hF, 4'h2);
        checkOutput("halted_r2", bus.dbg_data, 64'd0);
        checkOutput("halted_retired", 64'(bus.retired), 64'd6);
        stepClock();
        doReset();
        idle(4'h2, 4'h4);
        checkOutput("unhalt_flag", 64'(bus.halted), 64'd0);
        checkOutput("unhalt_retired", 64'(bus.retired), 64'd0);
        checkOutput("unhalt_r4", bus.dbg_data, 64'd0);
        stepClock();

        loadInstr(4'h6, 1'b0, 4'h0, 4'h5, 64'd77, 64'd0, 3'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'h6, 1'b0, 4'h0, 4'h6, 64'd99, 64'd0, 3'd1, 1'b1, 1'b0, 4'h5, 4'h6, 4'h5);
            stepClock();
        end
        idle(4'hF, 4'h5); stepClock();
        idle(4'hF, 4'h5);
        checkOutput("stall_r5", bus.dbg_data, 64'd77);
        checkOutput("stall_retired", 64'(bus.retired), 64'd1);
        stepClock();

        loadInstr(4'h6, 1'b0, 4'h0, 4'h6, 64'd66, 64'd0, 3'd1);
        applyStimulus(4'h6, 1'b0, 4'h0, 4'h7, 64'd5, 64'd0, 3'd1, 1'b1, 1'b1, 4'h6, 4'h7, 4'h7);
        stepClock();
        idle(4'hF, 4'h7);
        checkOutput("bub_dste", 64'(bus.w_dste), 64'hF);
        checkOutput("bub_stat", 64'(bus.w_stat), 64'd1);
        stepClock();
        idle(4'hF, 4'h7);
        checkOutput("bub_r7", bus.dbg_data, 64'd0);
        checkOutput("bub_retired", 64'(bus.retired), 64'd2);
        stepClock();

        for (int n = 0; n < 400; n++) begin
            if (ref_halted && $urandom_range(0, 3) == 0) begin
                doReset();
            end else begin
                applyStimulus(4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                              {$urandom(), $urandom()}, {$urandom(), $urandom()},
                              ($urandom_range(0, 49) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
                              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                              4'($urandom_range(0, 15)));
                stepClock();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_writeback_rf.md
# pipe_writeback_rf

Parametrised writeback stage and register file for the pipelined Y86-64 core. It latches the memory-stage results into a W pipeline register, decodes the destinations from icode/cnd, and commits up to two writes per cycle (dstE, dstM). It serves two decode read ports with same-cycle write bypass, and tracks halt status and retired-instruction count. It succeeds the single-port SEQ writeback by adding pipelining, stall/bubble control, dual write ports with priority, bypassed reads and status handling.

## Interface
- DATA_W, 64, register and value width
- ADDR_W, 4, register index width; index 2^ADDR_W-1 is RNONE (no register)
- NREG, 15, implemented registers (indices 0..NREG-1, NREG ≤ 2^ADDR_W-1)
- RSP_IDX, 4, stack pointer index
- CNT_W, 32, retired counter width

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- w_stall  in  1  hold W register
- w_bubble  in  1  load nop into W register
- m_icode  in  4  memory-stage icode
- m_cnd  in  1  condition flag
- m_ra, m_rb  in  ADDR_W  instruction register fields
- m_vale, m_valm  in  DATA_W  ALU / memory results
- m_stat  in  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS
- srca, srcb  in  ADDR_W  decode read addresses
- vala, valb  out  DATA_W  read data (bypassed)
- w_dste, w_dstm  out  ADDR_W  current W-stage destinations (for decode forwarding)
- w_vale, w_valm  out  DATA_W  current W-stage values
- w_stat  out  3  current W-stage status
- halted  out  1  sticky halt flag
- retired  out  CNT_W  count of committed instructions
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  register contents, unbypassed

## Operation
- W register fields: icode, cnd, ra, rb, vale, valm, stat. Update on each edge; priority is reset > w_bubble > w_stall > load.
- Bubble and reset value: icode=1 (nop), stat=1, all other fields 0.
- Destination decode from W fields:
  - dstE = rb for icode 3 and 6; for icode 2, rb only if cnd=1.
  - dstE = RSP_IDX for icode 8, 9, A, B.
  - dstE = RNONE otherwise.
  - dstM = ra for icode 5 and B; RNONE otherwise.
- Commit conditions: W stat == AOK and halted == 0. On commit, write vale to dstE and valm to dstM on the edge. RNONE and indices ≥ NREG are ignored.
- If dstE == dstM, valm wins (popq %rsp semantics).
- If W stat != AOK, no writes happen, halted sets on that edge and stays set until reset. Counter does not increment.
- Committed instruction: any W content with stat AOK while not halted, excluding bubbles (icode 1 loaded by bubble/reset), increments retired. retired wraps modulo 2^CNT_W.
- Reads:
  - If src == w_dstm and commit is active, return w_valm.
  - Else if src == w_dste and commit is active, return w_vale.
  - Else return the register value.
  - RNONE or ≥ NREG returns 0.
- dbg_data is the raw register value with no bypass; it returns 0 for out-of-range addresses.

## Timing
- Reset (synchronous): all registers 0, W = bubble, halted 0, retired 0. Outputs after the reset edge: w_dste/w_dstm = RNONE, w_stat = 1, vala/valb/dbg_data = 0.
- Latency: inputs are captured at edge N and written into the register file at edge N+1. dbg_data reflects the write after edge N+1.
- Bypass is combinational: a value is visible on vala/valb during the cycle in which it is committing.
- w_stall holds the W contents, but the held instruction is not re-committed: a stall after commit blocks duplicate writes and duplicate counts. Implement this with a commit-done bit that clears when new content loads.
- If w_stall and w_bubble are both asserted, w_bubble wins.
- Reset mid-stall or while halted clears everything; commits resume on the next loaded AOK instruction.

## Test plan
- OPq: icode=6, rb=8, vale=45, valm=33, stat=1 -> after 2 edges r8=45, all other registers 0, retired=1.
- cmovXX: icode=2, rb=4, vale=100, cnd=0 -> r4 unchanged and retired increments. Repeat with cnd=1 -> r4=100.
- ret then popq %rsp: icode=9, vale=20 -> r4=20. Then icode=B, ra=4, vale=28, valm=7 -> r4=7 (M priority).
- Bypass: W holds mrmovq with ra=3, valm=0xDEAD, and srca=3 in the same cycle -> vala=0xDEAD before the edge; dbg_data(3) still shows the old value.
- Halt: W stat=2 with icode=6, rb=1 -> r1 not written, halted=1. A later AOK OPq writes nothing until reset; after reset, halted=0 and retired=0.
- Stall/bubble: hold w_stall for 3 cycles on an OPq -> a single write and retired +1. Assert w_bubble together with w_stall -> W becomes a nop and no write occurs.
